// File: rtl/cdb_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cdb_arbiter_pkg
// Description : Shared machine widths and the CDB entry record used by FUBs
//               and the CDB arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package cdb_arbiter_pkg;

    localparam int C_NUM_FU   = 4;
    localparam int C_NUM_CDB  = 2;
    localparam int C_DATA_W   = 32;
    localparam int C_PREG_W   = 6;
    localparam int C_BMASK_W  = 4;
    localparam int C_BSPTR_W  = $clog2(C_BMASK_W);

    typedef logic [C_DATA_W-1:0]  data_t;
    typedef logic [C_PREG_W-1:0]  preg_t;
    typedef logic [C_BMASK_W-1:0] bmask_t;
    typedef logic [C_BSPTR_W-1:0] bsptr_t;

    typedef struct packed {
        logic   valid;
        data_t  result;
        preg_t  tag_dest;
        bmask_t bmask;
    } cdb_entry_t;

endpackage
`default_nettype wire

// File: rtl/cdb_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : cdb_arbiter_if
// Description : FUB head requests, branch resolution and CDB broadcast lanes.
// Revision    : 1.0 - initial release
// ============================================================================
interface cdb_arbiter_if #(
    parameter int NUM_FU  = cdb_arbiter_pkg::C_NUM_FU,
    parameter int NUM_CDB = cdb_arbiter_pkg::C_NUM_CDB
) ();
    import cdb_arbiter_pkg::*;

    logic   [NUM_FU-1:0]            fub_valid;
    data_t  [NUM_FU-1:0]            fub_result;
    preg_t  [NUM_FU-1:0]            fub_tagDest;
    bmask_t [NUM_FU-1:0]            fub_bmask;
    logic                           br_branch_resolved;
    logic                           br_pred_wrong;
    bsptr_t                         br_bs_ptr;
    logic   [NUM_FU-1:0]            cdb_stall;
    logic   [NUM_CDB-1:0]           cdb_valid;
    data_t  [NUM_CDB-1:0]           cdb_result;
    preg_t  [NUM_CDB-1:0]           cdb_tag;
    bmask_t [NUM_CDB-1:0]           cdb_bmask;

    // master: the arbiter; slave: the FUBs / branch unit / CDB consumers
    modport master (
        input  fub_valid, fub_result, fub_tagDest, fub_bmask,
        input  br_branch_resolved, br_pred_wrong, br_bs_ptr,
        output cdb_stall, cdb_valid, cdb_result, cdb_tag, cdb_bmask
    );

    modport slave (
        output fub_valid, fub_result, fub_tagDest, fub_bmask,
        output br_branch_resolved, br_pred_wrong, br_bs_ptr,
        input  cdb_stall, cdb_valid, cdb_result, cdb_tag, cdb_bmask
    );

endinterface
`default_nettype wire

// File: rtl/cdb_arbiter_rr_picker.sv
`default_nettype none
// ============================================================================
// Module      : cdb_arbiter_rr_picker
// Description : Grants up to NUM_CDB requesters scanning round-robin from a
//               start index; k-th grant in scan order drives lane k.
// Revision    : 1.0 - initial release
// ============================================================================
module cdb_arbiter_rr_picker #(
    parameter  int NUM_FU  = 4,
    parameter  int NUM_CDB = 2,
    localparam int FU_W    = $clog2(NUM_FU)
) (
    input  wire logic [NUM_FU-1:0]               i_req,
    input  wire logic [FU_W-1:0]                 i_start,
    output logic      [NUM_FU-1:0]               o_grant,
    output logic      [NUM_CDB-1:0][NUM_FU-1:0]  o_sel,
    output logic      [FU_W-1:0]                 o_last,
    output logic                                 o_any
);

    int w_idx;
    int w_cnt;

    always_comb begin
        o_grant = '0;
        o_sel   = '0;
        o_last  = '0;
        w_idx   = 0;
        w_cnt   = 0;
        for (int k = 0; k < NUM_FU; k++) begin
            w_idx = int'(i_start) + k;
            if (w_idx >= NUM_FU) begin
                w_idx = w_idx - NUM_FU;
            end
            if (i_req[w_idx] && (w_cnt < NUM_CDB)) begin
                o_grant[w_idx]      = 1'b1;
                o_sel[w_cnt][w_idx] = 1'b1;
                o_last              = FU_W'(w_idx);
                w_cnt               = w_cnt + 1;
            end
        end
    end

    assign o_any = |o_grant;

endmodule
`default_nettype wire

// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cdb_arbiter
// Description : Round-robin arbitration of FUB heads onto the CDB lanes with
//               mispredict squash and resolved-branch bmask clearing.
// Revision    : 1.0 - initial release
// ============================================================================
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter  int NUM_FU  = C_NUM_FU,
    parameter  int NUM_CDB = C_NUM_CDB,
    localparam int FU_W    = $clog2(NUM_FU)
) (
    input  wire logic   clk,
    input  wire logic   reset,
    cdb_arbiter_if.master bus
);

    logic [NUM_FU-1:0]              w_kill;
    logic [NUM_FU-1:0]              w_req;
    logic [NUM_FU-1:0]              w_grant;
    logic [NUM_CDB-1:0][NUM_FU-1:0] w_sel;
    logic [FU_W-1:0]                w_last;
    logic                           w_any;
    bmask_t                         w_clr;
    cdb_entry_t                     w_pick [NUM_CDB];
    cdb_entry_t                     r_lane [NUM_CDB];
    logic [FU_W-1:0]                r_rr;

    always_comb begin
        w_clr = '0;
        if (bus.br_branch_resolved && !bus.br_pred_wrong) begin
            w_clr[bus.br_bs_ptr] = 1'b1;
        end
    end

    always_comb begin
        w_kill = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            w_kill[i] = bus.br_branch_resolved & bus.br_pred_wrong
                      & bus.fub_bmask[i][bus.br_bs_ptr];
        end
    end

    assign w_req         = bus.fub_valid & ~w_kill;
    // killed heads are dropped by the FUB itself, so they never stall
    assign bus.cdb_stall = w_req & ~w_grant;

    cdb_arbiter_rr_picker #(
        .NUM_FU  (NUM_FU),
        .NUM_CDB (NUM_CDB)
    ) u_picker (
        .i_req   (w_req),
        .i_start (r_rr),
        .o_grant (w_grant),
        .o_sel   (w_sel),
        .o_last  (w_last),
        .o_any   (w_any)
    );

    always_comb begin
        for (int k = 0; k < NUM_CDB; k++) begin
            w_pick[k] = '0;
            for (int i = 0; i < NUM_FU; i++) begin
                if (w_sel[k][i]) begin
                    w_pick[k].valid    = 1'b1;
                    w_pick[k].result   = bus.fub_result[i];
                    w_pick[k].tag_dest = bus.fub_tagDest[i];
                    w_pick[k].bmask    = bus.fub_bmask[i] & ~w_clr;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < NUM_CDB; k++) begin
                r_lane[k] <= '0;
            end
            r_rr <= '0;
        end else begin
            for (int k = 0; k < NUM_CDB; k++) begin
                if (w_pick[k].valid) begin
                    r_lane[k] <= w_pick[k];
                end else begin
                    r_lane[k].valid <= 1'b0;
                    r_lane[k].bmask <= r_lane[k].bmask & ~w_clr;
                end
            end
            if (w_any) begin
                r_rr <= (w_last == FU_W'(NUM_FU - 1)) ? '0 : w_last + 1'b1;
            end
        end
    end

    generate
        for (genvar k = 0; k < NUM_CDB; k++) begin : g_lane
            assign bus.cdb_valid[k]  = r_lane[k].valid;
            assign bus.cdb_result[k] = r_lane[k].result;
            assign bus.cdb_tag[k]    = r_lane[k].tag_dest;
            assign bus.cdb_bmask[k]  = r_lane[k].bmask;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cdb_arbiter
// Description : Directed vector table plus reset / held-bmask sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    cdb_arbiter_if bus ();

    cdb_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [3:0]  valid;
        logic [15:0] bmask;
        logic        res;
        logic        wrong;
        logic [1:0]  ptr;
        logic [3:0]  exp_stall;
        logic [1:0]  exp_cv;
        int          f0;
        int          f1;
        logic [3:0]  b0;
        logic [3:0]  b1;
    } vec_t;

    vec_t tbl [11];

    function automatic vec_t mk(logic [3:0] v, logic [15:0] bm, logic r, logic w,
                                logic [1:0] p, logic [3:0] st, logic [1:0] cv,
                                int f0, int f1, logic [3:0] b0, logic [3:0] b1);
        vec_t t;
        t.valid = v; t.bmask = bm; t.res = r; t.wrong = w; t.ptr = p;
        t.exp_stall = st; t.exp_cv = cv; t.f0 = f0; t.f1 = f1; t.b0 = b0; t.b1 = b1;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [3:0] v, input logic [15:0] bm, input logic r,
                         input logic w, input logic [1:0] p);
        bus.fub_valid          = v;
        for (int i = 0; i < 4; i++) bus.fub_bmask[i] = bm[4*i +: 4];
        bus.br_branch_resolved = r;
        bus.br_pred_wrong      = w;
        bus.br_bs_ptr          = p;
    endtask

    initial begin
        // valid  bmask    res wrong ptr stall    cv     f0 f1  b0       b1
        tbl[0]  = mk(4'b1111, 16'h0000, 0, 0, 2'd0, 4'b1100, 2'b11, 0, 1, 4'h0, 4'h0);
        tbl[1]  = mk(4'b1111, 16'h0000, 0, 0, 2'd0, 4'b0011, 2'b11, 2, 3, 4'h0, 4'h0);
        tbl[2]  = mk(4'b1111, 16'h0000, 0, 0, 2'd0, 4'b1100, 2'b11, 0, 1, 4'h0, 4'h0);
        tbl[3]  = mk(4'b0100, 16'h0000, 0, 0, 2'd0, 4'b0000, 2'b01, 2, 0, 4'h0, 4'h0);
        tbl[4]  = mk(4'b1001, 16'h0000, 0, 0, 2'd0, 4'b0000, 2'b11, 3, 0, 4'h0, 4'h0);
        tbl[5]  = mk(4'b0011, 16'h0040, 1, 1, 2'd2, 4'b0000, 2'b01, 0, 0, 4'h0, 4'h0);
        tbl[6]  = mk(4'b0100, 16'h0200, 1, 0, 2'd1, 4'b0000, 2'b01, 2, 0, 4'h0, 4'h0);
        tbl[7]  = mk(4'b0000, 16'h0000, 0, 0, 2'd0, 4'b0000, 2'b00, 0, 0, 4'h0, 4'h0);
        tbl[8]  = mk(4'b1111, 16'h0000, 0, 0, 2'd0, 4'b0110, 2'b11, 3, 0, 4'h0, 4'h0);
        tbl[9]  = mk(4'b1111, 16'h0100, 1, 1, 2'd0, 4'b0001, 2'b11, 1, 3, 4'h0, 4'h0);
        tbl[10] = mk(4'b0011, 16'h0089, 1, 0, 2'd3, 4'b0000, 2'b11, 0, 1, 4'h1, 4'h0);

        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.fub_tagDest[i] = preg_t'(10 + i);
            bus.fub_result[i]  = data_t'(32'hA0 + i);
        end
        drive(4'b0000, 16'h0000, 1'b0, 1'b0, 2'd0);
        repeat (2) @(negedge clk);
        chk("rst_cdb_valid", 32'(bus.cdb_valid), 32'h0);
        chk("rst_cdb_tag0", 32'(bus.cdb_tag[0]), 32'h0);
        chk("rst_cdb_result1", bus.cdb_result[1], 32'h0);
        chk("rst_cdb_bmask0", 32'(bus.cdb_bmask[0]), 32'h0);
        chk("rst_stall", 32'(bus.cdb_stall), 32'h0);
        reset = 1'b1;

        for (int v = 0; v < 11; v++) begin
            @(negedge clk);
            drive(tbl[v].valid, tbl[v].bmask, tbl[v].res, tbl[v].wrong, tbl[v].ptr);
            #1;
            chk($sformatf("v%0d_stall", v), 32'(bus.cdb_stall), 32'(tbl[v].exp_stall));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_cdb_valid", v), 32'(bus.cdb_valid), 32'(tbl[v].exp_cv));
            if (tbl[v].exp_cv[0]) begin
                chk($sformatf("v%0d_tag0", v), 32'(bus.cdb_tag[0]), 32'(10 + tbl[v].f0));
                chk($sformatf("v%0d_res0", v), bus.cdb_result[0], 32'hA0 + 32'(tbl[v].f0));
                chk($sformatf("v%0d_bmask0", v), 32'(bus.cdb_bmask[0]), 32'(tbl[v].b0));
            end
            if (tbl[v].exp_cv[1]) begin
                chk($sformatf("v%0d_tag1", v), 32'(bus.cdb_tag[1]), 32'(10 + tbl[v].f1));
                chk($sformatf("v%0d_bmask1", v), 32'(bus.cdb_bmask[1]), 32'(tbl[v].b1));
            end
        end

        // asynchronous reset while both lanes broadcast
        #1;
        drive(4'b0000, 16'h0000, 1'b0, 1'b0, 2'd0);
        reset = 1'b0;
        #1;
        chk("midrst_cdb_valid", 32'(bus.cdb_valid), 32'h0);
        chk("midrst_tag1", 32'(bus.cdb_tag[1]), 32'h0);
        chk("midrst_stall", 32'(bus.cdb_stall), 32'h0);
        @(negedge clk);
        reset = 1'b1;
        drive(4'b1111, 16'h0000, 1'b0, 1'b0, 2'd0);
        #1;
        chk("postrst_stall", 32'(bus.cdb_stall), 32'b1100);
        @(posedge clk);
        #1;
        chk("postrst_tag0", 32'(bus.cdb_tag[0]), 32'd10);
        chk("postrst_tag1", 32'(bus.cdb_tag[1]), 32'd11);

        // held lane bmask cleared by a correct resolve with no new grant
        @(negedge clk);
        drive(4'b0010, 16'h0020, 1'b0, 1'b0, 2'd0);
        @(posedge clk);
        #1;
        chk("hold_cdb_valid", 32'(bus.cdb_valid), 32'b01);
        chk("hold_tag0", 32'(bus.cdb_tag[0]), 32'd11);
        chk("hold_bmask0", 32'(bus.cdb_bmask[0]), 32'h2);
        @(negedge clk);
        drive(4'b0000, 16'h0000, 1'b1, 1'b0, 2'd1);
        #1;
        chk("hold_bmask0_same_cycle", 32'(bus.cdb_bmask[0]), 32'h2);
        @(posedge clk);
        #1;
        chk("hold_bmask0_cleared", 32'(bus.cdb_bmask[0]), 32'h0);
        chk("idle_cdb_valid", 32'(bus.cdb_valid), 32'h0);

        // pointer held across the idle cycle: scan starts at FU2
        @(negedge clk);
        drive(4'b1111, 16'h0000, 1'b0, 1'b0, 2'd0);
        #1;
        chk("idle_rr_stall", 32'(bus.cdb_stall), 32'b0011);
        @(posedge clk);
        #1;
        chk("idle_rr_tag0", 32'(bus.cdb_tag[0]), 32'd12);
        chk("idle_rr_tag1", 32'(bus.cdb_tag[1]), 32'd13);

        @(negedge clk);
        drive(4'b0000, 16'h0000, 1'b0, 1'b0, 2'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
